// File: rtl/uart_tx_module.sv
// uart_tx_module: clk16x UART transmitter (start/data LSB-first/parity/stop) with a one-entry holding register
module uart_tx_module #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk16x,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n, hold, hold_n;
  logic par, par_n, hold_full, hold_full_n, tx_n, busy_n, done_n;
  logic bit_end, stop_last, load, accept;
  assign tx_ready = ~hold_full;
  always_comb begin
    bit_end = tick == TW'(OVERSAMPLE - 1);
    stop_last = stop_idx == 1'(STOP_BITS - 1);
    load = hold_full && (state == IDLE || (state == STOP && bit_end && stop_last));
    accept = tx_start && !hold_full;
    state_n = state;
    tick_n = (state == IDLE || bit_end) ? '0 : tick + TW'(1);
    bit_idx_n = bit_idx;
    stop_idx_n = stop_idx;
    shift_n = shift;
    par_n = par;
    done_n = 1'b0;
    case (state)
      IDLE: state_n = load ? START : IDLE;
      START: if (bit_end) begin
        state_n = DATA;
        bit_idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'(DATA_BITS - 1)) begin
          state_n = PARITY_EN != 0 ? PARITY : STOP;
          stop_idx_n = 1'b0;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        stop_idx_n = 1'b0;
      end
      STOP: if (bit_end) begin
        stop_idx_n = stop_idx + 1'b1;
        if (stop_last) begin
          done_n = 1'b1;
          state_n = load ? START : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      shift_n = hold;
      par_n = ^hold ^ 1'(PARITY_ODD);
    end
    hold_full_n = accept | (hold_full & ~load);
    hold_n = accept ? tx_data : hold;
    // line level is registered from the next state so tx changes on the same edge as the state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk16x or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      shift <= '0;
      hold <= '0;
      par <= 1'b0;
      hold_full <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      bit_idx <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shift <= shift_n;
      hold <= hold_n;
      par <= par_n;
      hold_full <= hold_full_n;
      tx <= tx_n;
      busy <= busy_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: directed vector and sequence checks for uart_tx_module in 8N1, 8E1, 8O1 and 8N2 builds
module tb_uart_tx_module;
  typedef struct {
    int         cfg;
    logic [7:0] data;
    logic [11:0] bits;
    int         nbits;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_v[4];
  logic [7:0] data_v[4];
  logic ready_v[4], tx_v[4], busy_v[4], done_v[4];
  int total = 0;
  int bad = 0;
  vec_t vt[6];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_module #(
      .PARITY_EN((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD(g == 2 ? 1 : 0),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) u_dut (
      .clk16x(clk),
      .rst_n(rst_n),
      .tx_start(start_v[g]),
      .tx_data(data_v[g]),
      .tx_ready(ready_v[g]),
      .tx(tx_v[g]),
      .busy(busy_v[g]),
      .tx_done(done_v[g])
    );
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic send(input int k, input logic [7:0] d);
    start_v[k] = 1'b1;
    data_v[k] = d;
    tick();
    start_v[k] = 1'b0;
    data_v[k] = 8'hEE;
  endtask
  task automatic run_frame(input int idx, input vec_t v);
    logic [15:0] s_tx, s_busy, s_done;
    logic r1;
    r1 = 1'b0;
    send(v.cfg, v.data);
    chk($sformatf("v%0d_ready_after_accept", idx), ready_v[v.cfg], 0);
    for (int b = 0; b < v.nbits; b++) begin
      for (int c = 0; c < 16; c++) begin
        tick();
        if (b == 0 && c == 0) r1 = ready_v[v.cfg];
        s_tx[c] = tx_v[v.cfg];
        s_busy[c] = busy_v[v.cfg];
        s_done[c] = done_v[v.cfg];
      end
      chk($sformatf("v%0d_tx_bit%0d", idx, b), s_tx, v.bits[b] ? 16'hFFFF : 16'h0000);
      chk($sformatf("v%0d_busy_bit%0d", idx, b), s_busy, 16'hFFFF);
      chk($sformatf("v%0d_done_bit%0d", idx, b), s_done, 16'h0000);
    end
    chk($sformatf("v%0d_ready_after_load", idx), r1, 1);
    tick();
    chk($sformatf("v%0d_done_pulse", idx), done_v[v.cfg], 1);
    chk($sformatf("v%0d_busy_end", idx), busy_v[v.cfg], 0);
    chk($sformatf("v%0d_tx_idle", idx), tx_v[v.cfg], 1);
    tick();
    chk($sformatf("v%0d_done_one_cycle", idx), done_v[v.cfg], 0);
  endtask
  task automatic rx_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    do begin
      tick();
      n++;
    end while (tx_v[0] !== 1'b0 && n < 400);
    chk("rx_start_seen", tx_v[0], 0);
    if (tx_v[0] === 1'b0) begin
      repeat (7) tick();
      chk("rx_start_mid", tx_v[0], 0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) tick();
        b[i] = tx_v[0];
      end
      repeat (16) tick();
      chk("rx_stop_mid", tx_v[0], 1);
    end
  endtask
  initial begin
    logic [7:0] r1, r2;
    logic [19:0] seq;
    int err_tx, busy_low, ndone, d1, d2, lows;
    logic [7:0] lb[4];
    vt[0] = '{0, 8'h55, 12'h2AA, 10};
    vt[1] = '{0, 8'h00, 12'h200, 10};
    vt[2] = '{1, 8'h07, 12'h60E, 11};
    vt[3] = '{2, 8'h07, 12'h40E, 11};
    vt[4] = '{3, 8'hFF, 12'h7FE, 11};
    vt[5] = '{1, 8'hA5, 12'h54A, 11};
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      data_v[i] = 8'h00;
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst%0d_tx", i), tx_v[i], 1);
      chk($sformatf("rst%0d_ready", i), ready_v[i], 1);
      chk($sformatf("rst%0d_busy", i), busy_v[i], 0);
      chk($sformatf("rst%0d_done", i), done_v[i], 0);
    end
    rst_n = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) run_frame(i, vt[i]);
    seq = {10'h278, 10'h34A};
    err_tx = 0;
    busy_low = 0;
    ndone = 0;
    d1 = 0;
    d2 = 0;
    send(0, 8'hA5);
    for (int c = 1; c <= 330; c++) begin
      tick();
      if (tx_v[0] !== (c <= 320 ? seq[(c - 1) / 16] : 1'b1)) err_tx++;
      if (c <= 320 && busy_v[0] !== 1'b1) busy_low++;
      if (done_v[0] === 1'b1) begin
        ndone++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 1) chk("b2b_ready_c1", ready_v[0], 1);
      if (c == 41) chk("b2b_ready_held", ready_v[0], 0);
      if (c == 161) chk("b2b_ready_reload", ready_v[0], 1);
      start_v[0] = c == 40;
      data_v[0] = c == 40 ? 8'h3C : 8'hEE;
    end
    chk("b2b_tx_errors", err_tx, 0);
    chk("b2b_busy_gaps", busy_low, 0);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_done1_cycle", d1, 161);
    chk("b2b_done2_cycle", d2, 321);
    fork
      begin
        rx_byte(r1);
        rx_byte(r2);
      end
      begin
        send(0, 8'h81);
        repeat (4) tick();
        send(0, 8'h3C);
        chk("ign_ready_full", ready_v[0], 0);
        start_v[0] = 1'b1;
        data_v[0] = 8'h12;
        tick();
        start_v[0] = 1'b0;
        data_v[0] = 8'hEE;
      end
    join
    chk("ign_first_byte", r1, 8'h81);
    chk("ign_second_byte", r2, 8'h3C);
    lows = 0;
    repeat (250) begin
      tick();
      if (tx_v[0] !== 1'b1) lows++;
    end
    chk("ign_no_third_frame", lows, 0);
    chk("ign_idle_busy", busy_v[0], 0);
    send(0, 8'hC3);
    repeat (19) tick();
    send(0, 8'h99);
    repeat (49) tick();
    chk("mid_busy_before_rst", busy_v[0], 1);
    chk("mid_ready_before_rst", ready_v[0], 0);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rst_tx", tx_v[0], 1);
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_ready", ready_v[0], 1);
    chk("mid_rst_done", done_v[0], 0);
    repeat (3) tick();
    rst_n = 1'b0;
    lows = 0;
    ndone = 0;
    repeat (200) begin
      tick();
      if (tx_v[0] !== 1'b1) lows++;
      if (done_v[0] !== 1'b0) ndone++;
    end
    chk("post_rst_line_idle", lows, 0);
    chk("post_rst_no_done", ndone, 0);
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h5A;
    lb[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      fork
        send(0, lb[i]);
        rx_byte(r1);
      join
      chk($sformatf("loop_%0d", i), r1, lb[i]);
    end
    repeat (20) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
UART transmitter, the transmit-side counterpart of the existing clk16x UART receiver. It serialises parallel bytes onto the line as start / data (LSB first) / optional parity / stop.
- Each bit lasts exactly OVERSAMPLE clk16x cycles, so the bit rate matches the receiver's 16x sampling (115200 baud).
- A one-entry holding register lets the host queue the next byte while the current frame is on the line, giving gap-free back-to-back frames.

Parameters:
OVERSAMPLE, 16, clk16x cycles per bit.
DATA_BITS, 8, data bits per frame (range 5..8).
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk16x    input   1          16x bit-rate clock; all logic on its rising edge.
rst_n     input   1          reset, asynchronous, active-high.
tx_start  input   1          host request: tx_data is valid this cycle.
tx_data   input   DATA_BITS  byte to send; sampled only on the accept edge.
tx_ready  output  1          holding register empty; tx_start is accepted.
tx        output  1          serial line; idles high.
busy      output  1          frame in progress (FSM not IDLE).
tx_done   output  1          1-cycle pulse after the last stop bit completes.

Behaviour:
- Reset is asynchronous and active-high; it takes effect immediately, including mid-frame. Values while rst_n=1:
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - hold_full=0; any held byte is discarded.
  - FSM=IDLE; bit-tick counter and bit index = 0.
- Outputs tx, busy and tx_done are registered; no combinational path from inputs.
- tx_ready = ~hold_full.
- Accept rule:
  - A byte is accepted on a rising edge where tx_start=1 and tx_ready=1. At that edge tx_data is latched into hold and hold_full is set.
  - tx_start while tx_ready=0 is ignored; hold is unchanged and no error is flagged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If hold_full=1: load shift register and parity accumulator from hold, clear hold_full, go to START, drive tx=0 at the same edge.
  - Latency: tx falls on the first edge after the accept edge.
- Tick counter runs 0..OVERSAMPLE-1 in every non-IDLE state. A bit ends when the counter is OVERSAMPLE-1; the counter wraps to 0 on the next edge.
- START: tx=0 for OVERSAMPLE cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0]; shift right at each bit end.
  - After bit index DATA_BITS-1 go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - tx = XOR of data bits, inverted when PARITY_ODD=1, so the total count of ones (data + parity) is odd.
  - Lasts OVERSAMPLE cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*OVERSAMPLE cycles.
  - At the final stop cycle's bit end, tx_done=1 for the next cycle.
  - If hold_full=1 at that edge: load the new byte and go straight to START (tx=0 next cycle, zero idle gap).
  - Otherwise go to IDLE.
- hold_full clears on the edge the FSM loads the byte; tx_ready rises on that same edge. The host may therefore queue byte N+1 while byte N's start bit is on the line.
- busy=1 in all states except IDLE. busy stays 1 across back-to-back frames.
- Frame length: 8N1 = 160 cycles, 8E1 = 176, 8N2 = 176.
- tx_data is don't-care except on the accept edge.

Test Plan:
- 8N1, reset then tx_start=1 with 0x55 for one cycle:
  - tx low for cycles 1-16.
  - Data bits 1,0,1,0,1,0,1,0 (16 cycles each).
  - Stop high for 16 cycles.
  - tx_done pulses once at cycle 161; busy high for cycles 1-160.
- Back-to-back, 0xA5 then 0x3C queued while 0xA5 is in DATA:
  - The second start bit follows the first stop bit with zero idle cycles.
  - Total 320 cycles; two tx_done pulses, 160 cycles apart.
- PARITY_EN=1, byte 0x07:
  - PARITY_ODD=0 gives parity bit 1.
  - PARITY_ODD=1 gives parity bit 0.
  - Frame is 176 cycles.
- STOP_BITS=2, byte 0xFF: stop high for exactly 32 cycles before tx_done; frame is 176 cycles.
- Ignored request: tx_start pulsed with 0x12 while tx_ready=0 (hold full) → 0x12 is never transmitted; only the already-held byte goes out.
- Reset and loopback:
  - Assert rst_n during the DATA bit-index 3 of 0xC3: tx=1 immediately, busy=0, tx_ready=1, and no tx_done.
  - After release, loop tx into the existing receiver: send 0x00, 0xFF, 0x5A, 0x81 and check that each is received intact.
